// File: rtl/gpio_ctrl_if.sv
// rtl/gpio_ctrl_if.sv - single-cycle strobe register bus between CPU and gpio_ctrl
interface gpio_ctrl_if;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (
    output stb,
    output we,
    output addr,
    output data_in,
    input  data_out,
    input  ack
  );

  modport slave (
    input  stb,
    input  we,
    input  addr,
    input  data_in,
    output data_out,
    output ack
  );
endinterface

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - register-mapped GPIO with input sync, rising-edge latch and level irq
module gpio_ctrl #(
  parameter int NUM_GPIO = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gpio_ctrl_if.slave          bus,
  output logic [NUM_GPIO-1:0] io_out,
  output logic [NUM_GPIO-1:0] io_tri,
  input  logic [NUM_GPIO-1:0] io_in,
  output logic                irq
);
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_IEN  = 2'd3;

  typedef logic [NUM_GPIO-1:0] pins_t;

  pins_t       out_q, out_d;
  pins_t       dir_q, dir_d;
  pins_t       stat_q, stat_d;
  pins_t       ien_q, ien_d;
  pins_t       s1_q, s2_q, s3_q;
  pins_t       rise;
  logic [1:0]  warm_q, warm_d;
  logic        req_q, req_we_q;
  logic [1:0]  req_addr_q;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic        irq_q, irq_d;
  logic        wr;

  always_comb begin
    wr     = bus.stb & bus.we;
    rise   = s2_q & ~s3_q;
    warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    out_d  = out_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    stat_d = stat_q;
    if (wr) begin
      case (bus.addr)
        ADDR_DATA: out_d  = bus.data_in[NUM_GPIO-1:0];
        ADDR_DIR:  dir_d  = bus.data_in[NUM_GPIO-1:0];
        ADDR_STAT: stat_d = stat_q & ~bus.data_in[NUM_GPIO-1:0];
        ADDR_IEN:  ien_d  = bus.data_in[NUM_GPIO-1:0];
        default:   out_d  = out_q;
      endcase
    end
    // Applied after the W1C clear so a same-cycle edge wins; masked until the sync chain is warm
    if (warm_q == 2'd3) begin
      stat_d = stat_d | rise;
    end
    irq_d = |(stat_q & ien_q);

    // Reads are served one edge after the strobe, so DATA sees s2 from the strobe edge
    rd_mux = '0;
    case (req_addr_q)
      ADDR_DATA: rd_mux[NUM_GPIO-1:0] = s2_q;
      ADDR_DIR:  rd_mux[NUM_GPIO-1:0] = dir_q;
      ADDR_STAT: rd_mux[NUM_GPIO-1:0] = stat_q;
      ADDR_IEN:  rd_mux[NUM_GPIO-1:0] = ien_q;
      default:   rd_mux = '0;
    endcase
    rdata_d = rdata_q;
    if (req_q) begin
      rdata_d = req_we_q ? 32'd0 : rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      dir_q      <= '0;
      stat_q     <= '0;
      ien_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      warm_q     <= 2'd0;
      req_q      <= 1'b0;
      req_we_q   <= 1'b0;
      req_addr_q <= 2'd0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      stat_q     <= stat_d;
      ien_q      <= ien_d;
      s1_q       <= io_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      warm_q     <= warm_d;
      req_q      <= bus.stb;
      req_we_q   <= bus.we;
      req_addr_q <= bus.addr;
      ack_q      <= req_q;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign io_out       = out_q;
  assign io_tri       = ~dir_q;
  assign irq          = irq_q;
  assign bus.ack      = ack_q;
  assign bus.data_out = rdata_q;
endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Register-mapped GPIO controller that sits directly upstream of the per-pin IO buffers. It drives each buffer's output value and tristate control and consumes the buffer's pin-in value. It also synchronises the inputs, detects rising edges and raises a level interrupt. The CPU accesses it through the codebase's single-cycle strobe IO bus.

## Interface
- NUM_GPIO, 8: number of pins, 1..32; register bits above NUM_GPIO-1 read 0 and ignore writes.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stb  in  1  bus strobe, one cycle per access.
- we  in  1  write enable, qualified by stb.
- addr  in  2  register select: 0 DATA, 1 DIR, 2 STAT, 3 IEN.
- data_in  in  32  write data.
- data_out  out  32  read data, registered.
- ack  out  1  access acknowledge, registered one-cycle pulse.
- io_out  out  NUM_GPIO  to buffer I (driven value).
- io_tri  out  NUM_GPIO  to buffer T; 1 = pin tristated (input).
- io_in  in  NUM_GPIO  from buffer O (pin level, asynchronous).
- irq  out  1  interrupt request, registered level.

## Operation
- Registers:
  - DATA write sets out_reg. DATA read returns the synchronised pin level s2, including pins configured as outputs (read-back of the driven level).
  - DIR: dir_reg, 1 = output. io_tri = ~dir_reg; io_out = out_reg.
  - STAT: per-pin rising-edge latch. Read returns the latch. Write is W1C: a 1 clears the bit, a 0 leaves it.
  - IEN: per-pin interrupt enable, read/write.
- Input path, per bit:
  - s1 <= io_in; s2 <= s1; s3 <= s2.
  - rise = s2 & ~s3.
- Edge latch:
  - STAT bit sets when rise=1 and warm-up is complete.
  - Set has priority over a W1C clear of the same bit in the same cycle.
  - Edges are detected regardless of DIR or IEN.
- Warm-up: a 2-bit counter counts 0->3 after reset release and saturates at 3. STAT updates are masked while counter < 3. This prevents false edges from pins that are already high at reset.
- irq <= |(STAT & IEN), registered.
- Reset values (rst_n low at a clock edge):
  - out_reg, dir_reg, STAT, IEN, s1..s3 = 0.
  - warm-up counter = 0; ack = 0; data_out = 0; irq = 0.
  - Consequence: io_tri = all 1s, io_out = all 0s.
- Reset mid-access: a strobe in the same cycle as reset is discarded. No write takes effect and no ack follows.
- stb with we=0 has no side effects. Reading STAT does not clear it.

## Timing
- Bus access:
  - stb sampled at edge n.
  - Write takes effect at edge n: the register and the io_out/io_tri outputs change after edge n.
  - ack=1 and data_out valid during cycle n+1 (after edge n+1), for exactly one cycle.
  - data_out holds its previous value when no read is in progress. It is 0 for writes.
- Back-to-back strobes on consecutive cycles are supported. Each strobe gets its own ack, one cycle later.
- Input latency: io_in changes before edge k, then:
  - s1 captures it at edge k.
  - s2 captures it at k+1; a DATA read issued at k+1 sees the new value.
  - STAT sets at edge k+2.
  - irq asserts at edge k+3 if IEN is set.
- Clearing: a W1C write at edge n clears the STAT bit at n. irq deasserts at n+1, unless the bit was re-set in the same cycle.
- Warm-up: the first edge able to set STAT is the 4th clock edge after rst_n goes high.

## Test plan
- Reset: hold rst_n=0 for 2 clocks with io_in=8'hFF -> io_tri=8'hFF, io_out=0, irq=0, ack=0. After release, STAT reads 0, because warm-up masks the false edge.
- Output drive: write DIR=8'h0F, then DATA=8'hA5 -> io_tri=8'hF0 and io_out=8'hA5 after the write edge. ack pulses one cycle after each stb. A DATA read, with the pins looped back, returns 8'h05 on bits 3:0.
- Edge + irq: IEN=8'h04; raise io_in[2] before edge k -> STAT reads 8'h04, and irq rises exactly at edge k+3. Raising io_in[3], which is not enabled, sets STAT bit 3 but leaves irq unchanged.
- W1C race: a rising edge on bit 2 reaches STAT in the same cycle as a STAT write of 8'h04 -> bit 2 stays 1 and irq stays 1. A second write of 8'h04 clears it, and irq drops one cycle later.
- Bus pipelining: 4 consecutive stb cycles (write IEN, read IEN, read DIR, read STAT) -> 4 consecutive ack pulses, each carrying the correct data_out. The read of IEN returns the value written one cycle earlier.
- Reset mid-operation: assert rst_n=0 coincident with a write of DIR=8'hFF -> no ack, dir_reg=0, io_tri=8'hFF.
